vga_config_bank: RTL

Runtime VGA timing configuration bank for the VGA_Control path. It has two register sets:

- **Shadow set:** written over a simple Addr/Data/Valid port, either field by field or by loading one of three built-in presets.
- **Active set:** drives the timing generator. The shadow set is copied into the active set only at a frame boundary, after a commit request, so a mode change never tears a frame.

It generalises the fixed preset selector with per-field writes, parametrised widths, deferred commit and optional consistency checking.

---
 rtl/vga_config_bank.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_config_bank.sv
// Runtime VGA timing configuration bank: a writable shadow set copied to the active set on a frame
// boundary after a commit. Define VGA_CONFIG_CHECK_EN to reject inconsistent timing on apply.
module vga_config_bank #(
  parameter int unsigned ADDR_WIDTH      = 4,
  parameter int unsigned DATA_WIDTH      = 11,
  parameter int unsigned REZ_MAX_WIDTH   = 11,
  parameter int unsigned PULSE_WIDTH     = 8,
  parameter int unsigned HL_MARGIN_WIDTH = 8,
  parameter int unsigned HR_MARGIN_WIDTH = 6,
  parameter int unsigned VL_MARGIN_WIDTH = 6,
  parameter int unsigned VR_MARGIN_WIDTH = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Valid,
  input  logic [ADDR_WIDTH-1:0]      Addr,
  input  logic [DATA_WIDTH-1:0]      Data,
  input  logic                       Frame_end,
  output logic                       Load_config,
  output logic                       Pending,
  output logic                       Err,
  output logic [REZ_MAX_WIDTH-1:0]   H_count_max,
  output logic [PULSE_WIDTH-1:0]     H_sync_pulse,
  output logic [HL_MARGIN_WIDTH-1:0] H_left_margin,
  output logic [HR_MARGIN_WIDTH-1:0] H_right_margin,
  output logic [REZ_MAX_WIDTH-1:0]   V_count_max,
  output logic [PULSE_WIDTH-1:0]     V_sync_pulse,
  output logic [VL_MARGIN_WIDTH-1:0] V_left_margin,
  output logic [VR_MARGIN_WIDTH-1:0] V_right_margin
);

  // 640x480 preset doubles as the reset value of both register sets
  localparam logic [REZ_MAX_WIDTH-1:0]   P0HMax   = REZ_MAX_WIDTH'(799);
  localparam logic [PULSE_WIDTH-1:0]     P0HSync  = PULSE_WIDTH'(96);
  localparam logic [HL_MARGIN_WIDTH-1:0] P0HLeft  = HL_MARGIN_WIDTH'(48);
  localparam logic [HR_MARGIN_WIDTH-1:0] P0HRight = HR_MARGIN_WIDTH'(16);
  localparam logic [REZ_MAX_WIDTH-1:0]   P0VMax   = REZ_MAX_WIDTH'(524);
  localparam logic [PULSE_WIDTH-1:0]     P0VSync  = PULSE_WIDTH'(2);
  localparam logic [VL_MARGIN_WIDTH-1:0] P0VLeft  = VL_MARGIN_WIDTH'(33);
  localparam logic [VR_MARGIN_WIDTH-1:0] P0VRight = VR_MARGIN_WIDTH'(10);

  localparam logic [ADDR_WIDTH-1:0] AddrMode   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] AddrHMax   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrHSync  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] AddrHLeft  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] AddrHRight = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] AddrVMax   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] AddrVSync  = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] AddrVLeft  = ADDR_WIDTH'(7);
  localparam logic [ADDR_WIDTH-1:0] AddrVRight = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] AddrCommit = ADDR_WIDTH'(9);

  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  state_e state_q, state_d;

  logic [REZ_MAX_WIDTH-1:0]   sh_hmax_q,   sh_hmax_d,   act_hmax_q;
  logic [PULSE_WIDTH-1:0]     sh_hsync_q,  sh_hsync_d,  act_hsync_q;
  logic [HL_MARGIN_WIDTH-1:0] sh_hleft_q,  sh_hleft_d,  act_hleft_q;
  logic [HR_MARGIN_WIDTH-1:0] sh_hright_q, sh_hright_d, act_hright_q;
  logic [REZ_MAX_WIDTH-1:0]   sh_vmax_q,   sh_vmax_d,   act_vmax_q;
  logic [PULSE_WIDTH-1:0]     sh_vsync_q,  sh_vsync_d,  act_vsync_q;
  logic [VL_MARGIN_WIDTH-1:0] sh_vleft_q,  sh_vleft_d,  act_vleft_q;
  logic [VR_MARGIN_WIDTH-1:0] sh_vright_q, sh_vright_d, act_vright_q;

  logic load_q;
  logic commit_wr;
  logic apply_try;
  logic apply_ok;
  logic cfg_ok;

  assign commit_wr = Valid && (Addr == AddrCommit);
  assign apply_try = (state_q == StArmed) && Frame_end;
  assign apply_ok  = apply_try && cfg_ok;

`ifdef VGA_CONFIG_CHECK_EN
  localparam int unsigned SumW = DATA_WIDTH + 2;

  logic [SumW-1:0] h_sum;
  logic [SumW-1:0] v_sum;
  logic            err_q;

  // Sums are widened so three fields can never wrap before the compare
  assign h_sum  = SumW'(sh_hsync_q) + SumW'(sh_hleft_q) + SumW'(sh_hright_q);
  assign v_sum  = SumW'(sh_vsync_q) + SumW'(sh_vleft_q) + SumW'(sh_vright_q);
  assign cfg_ok = (h_sum < SumW'(sh_hmax_q)) && (v_sum < SumW'(sh_vmax_q));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err_q <= 1'b0;
    end else if (apply_try) begin
      err_q <= !cfg_ok;
    end
  end

  assign Err = err_q;
`else
  assign cfg_ok = 1'b1;
  assign Err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (commit_wr) state_d = StArmed;
      StArmed: if (Frame_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sh_hmax_d   = sh_hmax_q;
    sh_hsync_d  = sh_hsync_q;
    sh_hleft_d  = sh_hleft_q;
    sh_hright_d = sh_hright_q;
    sh_vmax_d   = sh_vmax_q;
    sh_vsync_d  = sh_vsync_q;
    sh_vleft_d  = sh_vleft_q;
    sh_vright_d = sh_vright_q;
    if (Valid) begin
      unique case (Addr)
        AddrMode: begin
          unique case (Data[1:0])
            2'd0: begin
              sh_hmax_d   = P0HMax;
              sh_hsync_d  = P0HSync;
              sh_hleft_d  = P0HLeft;
              sh_hright_d = P0HRight;
              sh_vmax_d   = P0VMax;
              sh_vsync_d  = P0VSync;
              sh_vleft_d  = P0VLeft;
              sh_vright_d = P0VRight;
            end
            2'd1: begin
              sh_hmax_d   = REZ_MAX_WIDTH'(1055);
              sh_hsync_d  = PULSE_WIDTH'(128);
              sh_hleft_d  = HL_MARGIN_WIDTH'(88);
              sh_hright_d = HR_MARGIN_WIDTH'(40);
              sh_vmax_d   = REZ_MAX_WIDTH'(627);
              sh_vsync_d  = PULSE_WIDTH'(4);
              sh_vleft_d  = VL_MARGIN_WIDTH'(23);
              sh_vright_d = VR_MARGIN_WIDTH'(1);
            end
            2'd2: begin
              sh_hmax_d   = REZ_MAX_WIDTH'(1343);
              sh_hsync_d  = PULSE_WIDTH'(136);
              sh_hleft_d  = HL_MARGIN_WIDTH'(160);
              sh_hright_d = HR_MARGIN_WIDTH'(24);
              sh_vmax_d   = REZ_MAX_WIDTH'(805);
              sh_vsync_d  = PULSE_WIDTH'(6);
              sh_vleft_d  = VL_MARGIN_WIDTH'(29);
              sh_vright_d = VR_MARGIN_WIDTH'(3);
            end
            default: ;
          endcase
        end
        AddrHMax:   sh_hmax_d   = Data[REZ_MAX_WIDTH-1:0];
        AddrHSync:  sh_hsync_d  = Data[PULSE_WIDTH-1:0];
        AddrHLeft:  sh_hleft_d  = Data[HL_MARGIN_WIDTH-1:0];
        AddrHRight: sh_hright_d = Data[HR_MARGIN_WIDTH-1:0];
        AddrVMax:   sh_vmax_d   = Data[REZ_MAX_WIDTH-1:0];
        AddrVSync:  sh_vsync_d  = Data[PULSE_WIDTH-1:0];
        AddrVLeft:  sh_vleft_d  = Data[VL_MARGIN_WIDTH-1:0];
        AddrVRight: sh_vright_d = Data[VR_MARGIN_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= StIdle;
      load_q      <= 1'b0;
      sh_hmax_q   <= P0HMax;
      sh_hsync_q  <= P0HSync;
      sh_hleft_q  <= P0HLeft;
      sh_hright_q <= P0HRight;
      sh_vmax_q   <= P0VMax;
      sh_vsync_q  <= P0VSync;
      sh_vleft_q  <= P0VLeft;
      sh_vright_q <= P0VRight;
    end else begin
      state_q     <= state_d;
      load_q      <= apply_ok;
      sh_hmax_q   <= sh_hmax_d;
      sh_hsync_q  <= sh_hsync_d;
      sh_hleft_q  <= sh_hleft_d;
      sh_hright_q <= sh_hright_d;
      sh_vmax_q   <= sh_vmax_d;
      sh_vsync_q  <= sh_vsync_d;
      sh_vleft_q  <= sh_vleft_d;
      sh_vright_q <= sh_vright_d;
    end
  end

  // Copies the registered (pre-write) shadow, so a same-cycle field write waits for a new commit
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      act_hmax_q   <= P0HMax;
      act_hsync_q  <= P0HSync;
      act_hleft_q  <= P0HLeft;
      act_hright_q <= P0HRight;
      act_vmax_q   <= P0VMax;
      act_vsync_q  <= P0VSync;
      act_vleft_q  <= P0VLeft;
      act_vright_q <= P0VRight;
    end else if (apply_ok) begin
      act_hmax_q   <= sh_hmax_q;
      act_hsync_q  <= sh_hsync_q;
      act_hleft_q  <= sh_hleft_q;
      act_hright_q <= sh_hright_q;
      act_vmax_q   <= sh_vmax_q;
      act_vsync_q  <= sh_vsync_q;
      act_vleft_q  <= sh_vleft_q;
      act_vright_q <= sh_vright_q;
    end
  end

  assign Load_config    = load_q;
  assign Pending        = (state_q == StArmed);
  assign H_count_max    = act_hmax_q;
  assign H_sync_pulse   = act_hsync_q;
  assign H_left_margin  = act_hleft_q;
  assign H_right_margin = act_hright_q;
  assign V_count_max    = act_vmax_q;
  assign V_sync_pulse   = act_vsync_q;
  assign V_left_margin  = act_vleft_q;
  assign V_right_margin = act_vright_q;

endmodule
